// File: rtl/vd_pkg.sv
// Shared constants and state encoding for the convolutional encoder front end.
// Defaults describe the standard K=3 (7,5) code with 8-bit frames.
package vd_pkg;

    localparam int WD_CODE       = 2;
    localparam int K_DEF         = 3;
    localparam logic [2:0] G0_DEF = 3'b111;
    localparam logic [2:0] G1_DEF = 3'b101;
    localparam int FRAME_LEN_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TAIL  = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/vd_parity.sv
// Combinational XOR reduction of the tap vector masked by one generator polynomial.
module vd_parity #(
    parameter int         W    = 3,
    parameter logic [W-1:0] POLY = '1
) (
    input  logic [W-1:0] taps,
    output logic         parity
);

    assign parity = ^(taps & POLY);

endmodule

// File: rtl/vd_conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with framing, zero-tail termination
// and a registered valid/ready output slot; one symbol per clock at full throughput.
module vd_conv_encoder
    import vd_pkg::*;
#(
    parameter int           K         = K_DEF,
    parameter logic [K-1:0] G0        = K'(G0_DEF),
    parameter logic [K-1:0] G1        = K'(G1_DEF),
    parameter int           FRAME_LEN = FRAME_LEN_DEF,
    parameter int           CNT_W     = 8
) (
    input  logic               CLOCK,
    input  logic               Reset,
    input  logic               start,
    input  logic               in_bit,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WD_CODE-1:0] Code,
    output logic               code_valid,
    input  logic               code_ready,
    output logic               Active,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(K - 2);

    state_t             state_q, state_d;
    logic [K-2:0]       sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WD_CODE-1:0] code_q, code_d;
    logic               code_valid_q, code_valid_d;
    logic               active_q, active_d;
    logic               frame_done_q, frame_done_d;

    logic         slot_free;
    logic         load;
    logic         u;
    logic [K-1:0] taps;
    logic         c1, c0;

    assign slot_free = !code_valid_q || code_ready;
    assign in_ready  = (state_q == DATA) && slot_free;
    // Tail bits are forced to zero so the trellis walks back to state 0.
    assign u         = (state_q == DATA) ? in_bit : 1'b0;
    assign taps      = {u, sr_q};

    vd_parity #(.W(K), .POLY(G0)) u_par_c1 (.taps(taps), .parity(c1));
    vd_parity #(.W(K), .POLY(G1)) u_par_c0 (.taps(taps), .parity(c0));

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        load         = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A start coinciding with the frame_done pulse is dropped.
                if (start && !frame_done_q) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (in_valid && in_ready) begin
                    load = 1'b1;
                    if (cnt_q == LAST_DATA) begin
                        cnt_d   = '0;
                        state_d = TAIL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    load = 1'b1;
                    if (cnt_q == LAST_TAIL) begin
                        cnt_d   = '0;
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (!code_valid_q) begin
                    frame_done_d = 1'b1;
                    sr_d         = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            sr_d = taps[K-1:1];
        end
        code_d       = load ? {c1, c0} : code_q;
        code_valid_d = load || (code_valid_q && !code_ready);
        active_d     = active_q || (load && (c1 || c0));
    end

    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            active_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            active_q     <= active_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign Code       = code_q;
    assign code_valid = code_valid_q;
    assign Active     = active_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_vd_conv_encoder.sv
// Scenario-driven bench: expected symbols come from a reference encoder model,
// queued at frame start and popped on every observed output transfer.
module tb_vd_conv_encoder;

    logic       CLOCK = 1'b0;
    logic       Reset = 1'b0;
    logic       start = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b1;
    logic       code_ready = 1'b1;
    logic       in_ready, code_valid, Active, busy, frame_done;
    logic [1:0] Code;

    int n_pass  = 0;
    int n_total = 0;
    logic [1:0] exp_q[$];

    always #5 CLOCK = ~CLOCK;

    vd_conv_encoder dut (
        .CLOCK(CLOCK), .Reset(Reset), .start(start), .in_bit(in_bit),
        .in_valid(in_valid), .in_ready(in_ready), .Code(Code),
        .code_valid(code_valid), .code_ready(code_ready), .Active(Active),
        .busy(busy), .frame_done(frame_done)
    );

    // Reference (7,5) encoder: taps {u, most recent, oldest}; data[0] goes first.
    task automatic push_model(input logic [7:0] data);
        logic [1:0] s;
        logic [2:0] t;
        logic       u;
        s = 2'b00;
        for (int i = 0; i < 10; i++) begin
            u = (i < 8) ? data[i] : 1'b0;
            t = {u, s};
            exp_q.push_back({^(t & 3'b111), ^(t & 3'b101)});
            s = {u, s[1]};
        end
    endtask

    task automatic run_frame(input logic [7:0] data, input int stall_at, input int stall_len,
                             input bit poke_start, output int n_sym, output bit act_first);
        int idx, cyc, last_x, done_c, idx_stall;
        bit stall, seen_first;
        logic [1:0] held, exp;
        idx = 0; cyc = 0; last_x = -10; done_c = -1; idx_stall = 0;
        seen_first = 0; held = 2'b00; n_sym = 0; act_first = 0;
        exp_q.delete();
        push_model(data);
        @(negedge CLOCK); start = 1'b1;
        @(negedge CLOCK); start = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy); else n_pass++;
        while (done_c < 0 && cyc < 100) begin
            stall      = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            code_ready = !stall;
            in_valid   = (idx < 8);
            in_bit     = (idx < 8) ? data[idx] : 1'b0;
            start      = poke_start && (cyc == 2);
            #1;
            if (frame_done) begin
                done_c = cyc;
                if (poke_start) start = 1'b1;
            end
            if (code_valid && !seen_first) begin
                seen_first = 1;
                act_first  = Active;
            end
            if (stall) begin
                if (cyc == stall_at) begin
                    held = Code;
                    idx_stall = idx;
                end else begin
                    n_total++;
                    if (Code !== held) $display("FAIL stall_code_stable: got %b want %b", Code, held);
                    else n_pass++;
                end
                n_total++;
                if (in_ready !== 1'b0 || code_valid !== 1'b1)
                    $display("FAIL stall_hs: in_ready=%b code_valid=%b want 0/1", in_ready, code_valid);
                else n_pass++;
            end
            if (cyc == stall_at + stall_len && stall_len > 0) begin
                n_total++;
                if (idx !== idx_stall) $display("FAIL stall_no_accept: got %0d bits want %0d", idx, idx_stall);
                else n_pass++;
            end
            if (code_valid && code_ready) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL extra_symbol: got %b want none", Code);
                end else begin
                    exp = exp_q.pop_front();
                    if (Code !== exp) $display("FAIL symbol_%0d: got %b want %b", n_sym, Code, exp);
                    else n_pass++;
                end
                n_sym++;
                last_x = cyc;
            end
            if (in_valid && in_ready) idx++;
            cyc++;
            @(negedge CLOCK);
        end
        start = 1'b0; in_valid = 1'b0; code_ready = 1'b1;
        n_total++;
        if (done_c < 0) $display("FAIL frame_done_timeout: got none want pulse");
        else if (done_c - last_x < 1 || done_c - last_x > 2)
            $display("FAIL frame_done_timing: got %0d cycles after last xfer want 1..2", done_c - last_x);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL missing_symbols: got %0d left want 0", exp_q.size());
        else n_pass++;
        n_total++;
        if (frame_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL after_done: frame_done=%b busy=%b want 0/0", frame_done, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLOCK);
        n_total++;
        if (Code !== 2'b00 || code_valid !== 1'b0 || Active !== 1'b0)
            $display("FAIL reset_out: Code=%b vld=%b Active=%b want 00/0/0", Code, code_valid, Active);
        else n_pass++;
        n_total++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_ctl: done=%b busy=%b rdy=%b want 0/0/0", frame_done, busy, in_ready);
        else n_pass++;
        start = 1'b0; in_valid = 1'b0; Reset = 1'b1;
        @(negedge CLOCK);
        n_total++;
        if (busy !== 1'b0 || code_valid !== 1'b0)
            $display("FAIL reset_idle: busy=%b vld=%b want 0/0", busy, code_valid);
        else n_pass++;
    endtask

    task automatic test_all_zero();
        int n; bit af;
        run_frame(8'h00, 1000, 0, 0, n, af);
        n_total++;
        if (n !== 10) $display("FAIL zero_count: got %0d want 10", n); else n_pass++;
        n_total++;
        if (Active !== 1'b0 || af !== 1'b0) $display("FAIL zero_active: got %b/%b want 0", Active, af);
        else n_pass++;
    endtask

    task automatic test_known_vector();
        int n; bit af;
        run_frame(8'b1000_1111, 1000, 0, 0, n, af);
        n_total++;
        if (n !== 10) $display("FAIL known_count: got %0d want 10", n); else n_pass++;
        n_total++;
        if (af !== 1'b1 || Active !== 1'b1) $display("FAIL known_active: got %b/%b want 1", af, Active);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int n; bit af;
        run_frame(8'b0110_1011, 3, 5, 0, n, af);
        n_total++;
        if (n !== 10) $display("FAIL bp_count: got %0d want 10", n); else n_pass++;
    endtask

    task automatic test_reset_in_tail();
        logic [7:0] data;
        int idx, n;
        bit af, saw_done, saw_vld;
        data = 8'b1000_1111;
        idx = 0; saw_done = 0; saw_vld = 0;
        @(negedge CLOCK); start = 1'b1;
        @(negedge CLOCK); start = 1'b0; code_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            in_valid = 1'b1;
            in_bit   = data[idx];
            #1;
            if (in_valid && in_ready) idx++;
            @(negedge CLOCK);
        end
        in_valid = 1'b0;
        Reset = 1'b0;
        @(negedge CLOCK);
        Reset = 1'b1;
        n_total++;
        if (code_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL tail_reset: vld=%b busy=%b want 0/0", code_valid, busy);
        else n_pass++;
        repeat (12) begin
            @(negedge CLOCK);
            if (frame_done) saw_done = 1;
            if (code_valid) saw_vld = 1;
        end
        n_total++;
        if (saw_done || saw_vld) $display("FAIL tail_reset_quiet: done=%b vld=%b want 0/0", saw_done, saw_vld);
        else n_pass++;
        run_frame(data, 1000, 0, 0, n, af);
        n_total++;
        if (n !== 10) $display("FAIL tail_reset_refill: got %0d want 10", n); else n_pass++;
    endtask

    task automatic test_ignored_start();
        int n; bit af;
        run_frame(8'b0101_0011, 1000, 0, 1, n, af);
        n_total++;
        if (n !== 10) $display("FAIL ign_start_count: got %0d want 10", n); else n_pass++;
        @(negedge CLOCK);
        n_total++;
        if (busy !== 1'b0 || code_valid !== 1'b0)
            $display("FAIL ign_start_idle: busy=%b vld=%b want 0/0", busy, code_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_known_vector();
        test_backpressure();
        test_reset_in_tail();
        test_ignored_start();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
